// File: rtl/rnn_cell_engine_if.sv
// Memory-mapped slave bus for the RNN cell engine.
// Word-addressed read/write strobes, registered read data, done level.
interface rnn_cell_engine_if;
   logic        read;
   logic        write;
   logic [31:0] addr;
   logic [31:0] data_in;
   logic [31:0] data_out;
   logic        irq;

   modport master (
      output read, write, addr, data_in,
      input  data_out, irq
   );

   modport slave (
      input  read, write, addr, data_in,
      output data_out, irq
   );
endinterface

// File: rtl/rnn_cell_engine.sv
// Elman RNN cell: h' = act(W0*x + W1*h + b), y = d*h' + db,
// computed with one sequential signed MAC per cycle.
module rnn_cell_engine #(
   parameter int IN_LEN    = 2,
   parameter int HID_LEN   = 4,
   parameter int FRAC_BITS = 8,
   parameter int ACC_W     = 40
) (
   input logic              clk,
   input logic              rst_n,
   rnn_cell_engine_if.slave bus
);

   localparam int IXW = (IN_LEN > 1) ? $clog2(IN_LEN) : 1;
   localparam int HXW = (HID_LEN > 1) ? $clog2(HID_LEN) : 1;
   localparam logic [7:0] IN_LAST  = 8'(IN_LEN - 1);
   localparam logic [7:0] HID_LAST = 8'(HID_LEN - 1);
   localparam logic signed [ACC_W-1:0] SMAX = ACC_W'(32767);
   localparam logic signed [ACC_W-1:0] SMIN = ACC_W'(-32768);
   localparam logic signed [15:0] ONE  = 16'(1 << FRAC_BITS);
   localparam logic signed [15:0] NONE = -ONE;

   typedef enum logic [2:0] {
      S_IDLE, S_MAC_X, S_MAC_H, S_WB,
      S_COMMIT, S_DENSE, S_OUT, S_DONE
   } state_t;

   state_t r_state, w_next;

   logic signed [15:0] r_x  [IN_LEN];
   logic signed [15:0] r_w0 [HID_LEN][IN_LEN];
   logic signed [15:0] r_w1 [HID_LEN][HID_LEN];
   logic signed [15:0] r_b  [HID_LEN];
   logic signed [15:0] r_d  [HID_LEN];
   logic signed [15:0] r_h  [HID_LEN];
   logic signed [15:0] r_hn [HID_LEN];
   logic signed [15:0] r_db;
   logic signed [15:0] r_y;

   logic [1:0]             r_act;
   logic                   r_done;
   logic [7:0]             r_row;
   logic [7:0]             r_col;
   logic [HXW-1:0]         r_rd_idx;
   logic signed [ACC_W-1:0] r_acc;
   logic [31:0]            r_dout;

   logic                    w_busy, w_wr, w_start;
   logic signed [15:0]      w_val;
   logic [7:0]              w_col, w_row;
   logic                    w_col_x, w_col_h, w_row_ok;
   logic [IXW-1:0]          w_hcx, w_cx;
   logic [HXW-1:0]          w_hch, w_hr, w_ch, w_ri;
   logic signed [15:0]      w_ma, w_mb;
   logic signed [31:0]      w_prod;
   logic signed [ACC_W-1:0] w_base, w_acc_nx, w_shift;
   logic                    w_first;
   logic signed [15:0]      w_sat, w_actv;

   assign w_busy  = (r_state != S_IDLE) && (r_state != S_DONE);
   assign w_wr    = bus.write && !w_busy;
   assign w_start = w_wr && (bus.addr == 32'd0);

   assign w_val    = bus.data_in[15:0];
   assign w_col    = bus.data_in[23:16];
   assign w_row    = bus.data_in[31:24];
   assign w_col_x  = (w_col <= IN_LAST);
   assign w_col_h  = (w_col <= HID_LAST);
   assign w_row_ok = (w_row <= HID_LAST);
   assign w_hcx    = w_col[IXW-1:0];
   assign w_hch    = w_col[HXW-1:0];
   assign w_hr     = w_row[HXW-1:0];

   assign w_ri = r_row[HXW-1:0];
   assign w_cx = r_col[IXW-1:0];
   assign w_ch = r_col[HXW-1:0];

   // The first MAC of a row/dense pass folds in the bias, so no load cycle
   always_comb begin
      w_ma    = '0;
      w_mb    = '0;
      w_base  = '0;
      w_first = 1'b0;
      case (r_state)
         S_MAC_X: begin
            w_ma    = r_w0[w_ri][w_cx];
            w_mb    = r_x[w_cx];
            w_base  = ACC_W'(r_b[w_ri]) <<< FRAC_BITS;
            w_first = (r_col == 8'd0);
         end
         S_MAC_H: begin
            w_ma = r_w1[w_ri][w_ch];
            w_mb = r_h[w_ch];
         end
         S_DENSE: begin
            w_ma    = r_d[w_ch];
            w_mb    = r_h[w_ch];
            w_base  = ACC_W'(r_db) <<< FRAC_BITS;
            w_first = (r_col == 8'd0);
         end
         default: ;
      endcase
   end

   assign w_prod   = w_ma * w_mb;
   assign w_acc_nx = (w_first ? w_base : r_acc) + ACC_W'(w_prod);
   assign w_shift  = r_acc >>> FRAC_BITS;

   always_comb begin
      w_sat = w_shift[15:0];
      if (w_shift > SMAX)
         w_sat = 16'sh7FFF;
      else if (w_shift < SMIN)
         w_sat = 16'sh8000;
   end

   always_comb begin
      w_actv = w_sat;
      case (r_act)
         2'd1: if (w_sat < 0) w_actv = '0;
         2'd2: begin
            if (w_sat > ONE)
               w_actv = ONE;
            else if (w_sat < NONE)
               w_actv = NONE;
         end
         default: ;
      endcase
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE, S_DONE:
            if (w_start) w_next = S_MAC_X;
         S_MAC_X:
            if (r_col == IN_LAST) w_next = S_MAC_H;
         S_MAC_H:
            if (r_col == HID_LAST) w_next = S_WB;
         S_WB:
            w_next = (r_row == HID_LAST) ? S_COMMIT : S_MAC_X;
         S_COMMIT:
            w_next = S_DENSE;
         S_DENSE:
            if (r_col == HID_LAST) w_next = S_OUT;
         S_OUT:
            w_next = S_DONE;
         default:
            w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= S_IDLE;
      else
         r_state <= w_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < IN_LEN; i++)
            r_x[i] <= '0;
         for (int i = 0; i < HID_LEN; i++) begin
            r_b[i]  <= '0;
            r_d[i]  <= '0;
            r_h[i]  <= '0;
            r_hn[i] <= '0;
            for (int j = 0; j < IN_LEN; j++)
               r_w0[i][j] <= '0;
            for (int j = 0; j < HID_LEN; j++)
               r_w1[i][j] <= '0;
         end
         r_db     <= '0;
         r_y      <= '0;
         r_act    <= '0;
         r_done   <= 1'b0;
         r_row    <= '0;
         r_col    <= '0;
         r_rd_idx <= '0;
         r_acc    <= '0;
      end else begin
         if (w_wr) begin
            case (bus.addr)
               32'd0: begin
                  r_act  <= bus.data_in[1:0];
                  r_done <= 1'b0;
                  r_row  <= '0;
                  r_col  <= '0;
                  if (bus.data_in[2])
                     for (int i = 0; i < HID_LEN; i++)
                        r_h[i] <= '0;
               end
               32'd1: if (w_col_x) r_x[w_hcx] <= w_val;
               32'd2: if (w_row_ok && w_col_x)
                  r_w0[w_hr][w_hcx] <= w_val;
               32'd3: if (w_row_ok && w_col_h)
                  r_w1[w_hr][w_hch] <= w_val;
               32'd4: if (w_col_h) r_b[w_hch] <= w_val;
               32'd5: if (w_col_h) r_d[w_hch] <= w_val;
               32'd6: r_db <= w_val;
               32'd8: if (w_col_h) begin
                  r_h[w_hch] <= w_val;
                  r_rd_idx   <= w_hch;
               end
               default: ;
            endcase
         end
         case (r_state)
            S_MAC_X: begin
               r_acc <= w_acc_nx;
               r_col <= (r_col == IN_LAST) ? 8'd0 : r_col + 8'd1;
            end
            S_MAC_H: begin
               r_acc <= w_acc_nx;
               r_col <= (r_col == HID_LAST) ? 8'd0 : r_col + 8'd1;
            end
            S_WB: begin
               r_hn[w_ri] <= w_actv;
               r_row      <= r_row + 8'd1;
               r_col      <= '0;
            end
            // Every row has read the old h; swap in the new state at once
            S_COMMIT:
               for (int i = 0; i < HID_LEN; i++)
                  r_h[i] <= r_hn[i];
            S_DENSE: begin
               r_acc <= w_acc_nx;
               r_col <= (r_col == HID_LAST) ? 8'd0 : r_col + 8'd1;
            end
            S_OUT: begin
               r_y    <= w_sat;
               r_done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_dout <= '0;
      else if (bus.read) begin
         case (bus.addr)
            32'd0:   r_dout <= {28'b0, r_act, r_done, w_busy};
            32'd7:   r_dout <= {{16{r_y[15]}}, r_y};
            32'd8:   r_dout <= {{16{r_h[r_rd_idx][15]}}, r_h[r_rd_idx]};
            default: r_dout <= '0;
         endcase
      end
   end

   assign bus.data_out = r_dout;
   assign bus.irq      = r_done;

endmodule

// File: tb/tb_rnn_cell_engine.sv
// Randomised scoreboard bench for rnn_cell_engine against a
// plain-arithmetic model of one Elman time step.
module tb_rnn_cell_engine;
   localparam int IN  = 2;
   localparam int HID = 4;
   localparam int F   = 8;
   localparam int L   = HID * (IN + HID + 1) + HID + 2;

   bit   clk;
   logic rst_n;
   rnn_cell_engine_if bus();

   rnn_cell_engine #(
      .IN_LEN(IN), .HID_LEN(HID), .FRAC_BITS(F), .ACC_W(40)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   logic [31:0] exp_q[$];
   string       tag_q[$];
   logic        rd_v;

   int mx[IN];
   int mw0[HID][IN];
   int mw1[HID][HID];
   int mb[HID];
   int md[HID];
   int mh[HID];
   int mdb, my, mact, mrd;

   always @(posedge clk or negedge rst_n)
      if (!rst_n) rd_v <= 1'b0;
      else        rd_v <= bus.read;

   always @(negedge clk) begin
      if (rd_v) begin
         logic [31:0] e;
         string t;
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_read got=%h", bus.data_out);
         end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            if (bus.data_out !== e) begin
               failures++;
               $display("FAIL %s got=%h exp=%h", t, bus.data_out, e);
            end
         end
      end
   end

   function automatic int s16(input int v);
      logic signed [15:0] t;
      t = v[15:0];
      return int'(t);
   endfunction

   function automatic int sat16(input longint v);
      if (v > 32767) return 32767;
      if (v < -32768) return -32768;
      return int'(v);
   endfunction

   function automatic int actf(input int v, input int m);
      int one;
      one = 1 << F;
      if (m == 1) return (v < 0) ? 0 : v;
      if (m == 2) return (v > one) ? one : ((v < -one) ? -one : v);
      return v;
   endfunction

   task automatic model_step(input int mode, input bit clr);
      int hn[HID];
      longint acc;
      if (clr) foreach (mh[i]) mh[i] = 0;
      for (int i = 0; i < HID; i++) begin
         acc = longint'(mb[i]) * (longint'(1) << F);
         for (int j = 0; j < IN; j++)
            acc += longint'(mw0[i][j]) * mx[j];
         for (int k = 0; k < HID; k++)
            acc += longint'(mw1[i][k]) * mh[k];
         hn[i] = actf(sat16(acc >>> F), mode);
      end
      mh = hn;
      acc = longint'(mdb) * (longint'(1) << F);
      for (int k = 0; k < HID; k++)
         acc += longint'(md[k]) * mh[k];
      my = sat16(acc >>> F);
      mact = mode;
   endtask

   task automatic model_reset();
      foreach (mx[j]) mx[j] = 0;
      for (int i = 0; i < HID; i++) begin
         mb[i] = 0; md[i] = 0; mh[i] = 0;
         for (int j = 0; j < IN; j++) mw0[i][j] = 0;
         for (int k = 0; k < HID; k++) mw1[i][k] = 0;
      end
      mdb = 0; my = 0; mact = 0; mrd = 0;
   endtask

   task automatic wr(input int a, input int row, input int col,
                     input int val);
      bus.write   = 1'b1;
      bus.addr    = 32'(a);
      bus.data_in = {row[7:0], col[7:0], val[15:0]};
      @(posedge clk); #1;
      bus.write = 1'b0;
   endtask

   task automatic rd(input int a, input logic [31:0] e,
                     input string t);
      bus.read = 1'b1;
      bus.addr = 32'(a);
      exp_q.push_back(e);
      tag_q.push_back(t);
      @(posedge clk); #1;
      bus.read = 1'b0;
   endtask

   task automatic chk_irq(input logic e, input string t);
      checks++;
      if (bus.irq !== e) begin
         failures++;
         $display("FAIL %s irq=%b exp=%b", t, bus.irq, e);
      end
   endtask

   task automatic load_model();
      for (int j = 0; j < IN; j++) wr(1, 0, j, mx[j]);
      for (int i = 0; i < HID; i++) begin
         for (int j = 0; j < IN; j++) wr(2, i, j, mw0[i][j]);
         for (int k = 0; k < HID; k++) wr(3, i, k, mw1[i][k]);
         wr(4, 0, i, mb[i]);
         wr(5, 0, i, md[i]);
      end
      wr(6, 0, 0, mdb);
   endtask

   task automatic set_basic();
      int r0[HID];
      int r1[HID];
      r0 = '{1, 0, 1, -1};
      r1 = '{0, 1, 1, 0};
      mx[0] = 'h100; mx[1] = 'h200;
      for (int i = 0; i < HID; i++) begin
         mw0[i][0] = r0[i] * 'h100;
         mw0[i][1] = r1[i] * 'h100;
         for (int k = 0; k < HID; k++) mw1[i][k] = 0;
         mb[i] = 0;
         md[i] = 'h100;
      end
      mdb = 'h80;
   endtask

   // Re-write h[j] with its own value (to aim the readback) while reading
   // the old index in the same cycle, then run one step and poll status.
   task automatic run(input int mode, input bit clr, input int j,
                      input bit perturb);
      logic [1:0] m;
      m = mode[1:0];
      bus.read    = 1'b1;
      bus.write   = 1'b1;
      bus.addr    = 32'd8;
      bus.data_in = {8'd0, 8'(j), mh[j][15:0]};
      exp_q.push_back(32'(mh[mrd]));
      tag_q.push_back("rw_same_addr");
      @(posedge clk); #1;
      bus.read = 1'b0; bus.write = 1'b0;
      mrd = j;
      bus.write   = 1'b1;
      bus.addr    = 32'd0;
      bus.data_in = {29'd0, clr, m};
      @(posedge clk); #1;
      bus.write = 1'b0;
      model_step(mode, clr);
      for (int k = 1; k <= L + 1; k++) begin
         if (perturb && k == 3)
            wr(1, 0, 0, 'h7FFF);
         else if (perturb && k == 7)
            wr(5, 0, 9, 'h1234);
         else if (perturb && k == 5) begin
            bus.write   = 1'b1;
            bus.data_in = 32'h5;
            rd(0, {28'd0, m, 2'b01}, "status_busy_start");
            bus.write = 1'b0;
         end else if (k <= L)
            rd(0, {28'd0, m, 2'b01}, "status_busy");
         else
            rd(0, {28'd0, m, 2'b10}, "status_done");
      end
      chk_irq(1'b1, "irq_done");
      rd(7, 32'(my), "y");
      rd(8, 32'(mh[j]), "h_sel");
   endtask

   initial begin
      bus.read = 1'b0; bus.write = 1'b0;
      bus.addr = '0; bus.data_in = '0;
      rst_n = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      rd(0, 32'd0, "rst_status");
      rd(7, 32'd0, "rst_y");
      rd(8, 32'd0, "rst_h");
      chk_irq(1'b0, "rst_irq");

      set_basic();
      load_model();
      for (int j = 0; j < HID; j++) run(1, 1'b1, j, 1'b0);

      for (int i = 0; i < HID; i++)
         for (int k = 0; k < HID; k++) begin
            mw1[i][k] = (i == k) ? 'h100 : 0;
            wr(3, i, k, mw1[i][k]);
         end
      for (int j = 0; j < HID; j++) begin
         run(1, 1'b1, j, 1'b0);
         run(1, 1'b0, j, 1'b0);
      end

      mx[0] = 'h6400; mx[1] = 'h6400;
      wr(1, 0, 0, mx[0]); wr(1, 0, 1, mx[1]);
      run(0, 1'b1, 2, 1'b0);
      run(0, 1'b1, 3, 1'b0);
      run(2, 1'b1, 2, 1'b0);
      run(2, 1'b1, 3, 1'b0);
      run(3, 1'b1, 3, 1'b0);

      set_basic();
      load_model();
      run(1, 1'b1, 1, 1'b1);
      run(1, 1'b1, 2, 1'b0);

      bus.read = 1'b1; bus.write = 1'b1; bus.addr = 32'd8;
      bus.data_in = {8'd0, 8'd9, 16'h5555};
      exp_q.push_back(32'(mh[mrd])); tag_q.push_back("h_bad_col_rw");
      @(posedge clk); #1;
      bus.read = 1'b0; bus.write = 1'b0;
      rd(8, 32'(mh[mrd]), "h_bad_col_after");

      wr(0, 0, 0, 4 + 1);
      repeat (9) @(posedge clk);
      #1 rst_n = 1'b0;
      model_reset();
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;
      rd(0, 32'd0, "midrst_status");
      rd(7, 32'd0, "midrst_y");
      rd(8, 32'd0, "midrst_h");
      chk_irq(1'b0, "midrst_irq");
      run(0, 1'b0, 3, 1'b0);

      set_basic();
      load_model();
      for (int j = 0; j < HID; j++) run(1, 1'b1, j, 1'b0);

      for (int n = 0; n < 12; n++) begin
         for (int j = 0; j < IN; j++) mx[j] = s16($urandom);
         for (int i = 0; i < HID; i++) begin
            for (int j = 0; j < IN; j++) mw0[i][j] = s16($urandom);
            for (int k = 0; k < HID; k++) mw1[i][k] = s16($urandom);
            mb[i] = s16($urandom);
            md[i] = s16($urandom);
         end
         mdb = s16($urandom);
         load_model();
         run(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             int'($urandom_range(0, HID - 1)),
             1'($urandom_range(0, 1)));
      end

      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL pending_reads got=%0d exp=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
